// File: rtl/visualizer_pkg.sv
// Shared types and widths for the audio-to-spectrum visualizer path.
package visualizer_pkg;

    localparam int SAMPLE_W    = 18;   // width of one deserialized audio sample
    localparam int NUM_TAPS    = 16;   // taps in the sample window t0..t15
    localparam int OVR_CNT_W   = 8;    // dropped-frame counter width
    localparam int SAMP_CNT_W  = 8;    // covers FRAME_LEN up to 255
    localparam int FRAME_CNT_W = 16;   // delivered-frame counter width
    localparam int WD_CNT_W    = 16;   // watchdog cycle counter width

    typedef enum logic [2:0] {
        FILL,
        SNAP,
        REQ,
        WAIT_DONE,
        PRESENT
    } sched_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [OVR_CNT_W-1:0] sat_inc(input logic [OVR_CNT_W-1:0] value);
        return (&value) ? value : value + OVR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/fft_frame_scheduler_if.sv
// Handshake bundle between the frame scheduler and the snapshot
// registers, the FFT core and the display stage.
interface fft_frame_scheduler_if;

    logic snap_en;      // latch t0..t15 into the FFT input registers
    logic fft_start;    // frame valid towards the FFT
    logic fft_ready;    // FFT accepts the frame
    logic fft_done;     // FFT result available (one-cycle pulse)
    logic frame_valid;  // spectrum valid towards the display
    logic disp_ready;   // display accepts the spectrum

    // Scheduler side.
    modport master (
        output snap_en, fft_start, frame_valid,
        input  fft_ready, fft_done, disp_ready
    );

    // FFT / display side.
    modport slave (
        input  snap_en, fft_start, frame_valid,
        output fft_ready, fft_done, disp_ready
    );

endinterface

// File: rtl/fft_frame_scheduler_hop_counter.sv
// Sample-strobe counter: counts new_t strobes towards FRAME_LEN before the
// first frame and towards HOP afterwards, and flags the strobe that
// completes a window.
module hop_counter
    import visualizer_pkg::*;
#(
    parameter int FRAME_LEN = 16,
    parameter int HOP       = 16
) (
    input  logic clk,
    input  logic reset,   // asynchronous, active low
    input  logic clear,   // abort: drop the partial window and de-prime
    input  logic new_t,   // one new sample entered the window this edge
    input  logic arm,     // scheduler is idle, so a completed window becomes a frame
    output logic hit      // this strobe completes the current target
);

    logic [SAMP_CNT_W-1:0] samp_cnt;
    logic                  primed;
    logic [SAMP_CNT_W-1:0] target_m1;

    assign target_m1 = primed ? SAMP_CNT_W'(HOP - 1) : SAMP_CNT_W'(FRAME_LEN - 1);
    assign hit       = new_t & ~clear & (samp_cnt == target_m1);

    // Count strobes; restart the window on every hit, prime on the first frame.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            samp_cnt <= '0;
            primed   <= 1'b0;
        end else if (clear) begin
            samp_cnt <= '0;
            primed   <= 1'b0;
        end else if (new_t) begin
            if (hit) begin
                samp_cnt <= '0;
                if (arm) begin
                    primed <= 1'b1;
                end
            end else begin
                samp_cnt <= samp_cnt + SAMP_CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/fft_frame_scheduler.sv
// Frame scheduler between the mic deserializer, the FFT core and the
// bar-graph renderer: snapshots complete sample windows, hands them to the
// FFT, presents the result and counts delivered and dropped frames.
// Optional watchdog on WAIT_DONE: define FFT_SCHED_WATCHDOG_EN.
module fft_frame_scheduler
    import visualizer_pkg::*;
#(
    parameter int FRAME_LEN = 16,
    parameter int HOP       = 16
`ifdef FFT_SCHED_WATCHDOG_EN
    ,
    parameter int TIMEOUT   = 4096
`endif
) (
    input  logic                    clk,
    input  logic                    reset,   // asynchronous, active low
    input  logic                    run,
    input  logic                    new_t,
    fft_frame_scheduler_if.master   link,
    output logic                    overrun,
    output logic [OVR_CNT_W-1:0]    overrun_cnt,
    output logic [FRAME_CNT_W-1:0]  frame_cnt,
    output logic                    timeout_err
);

    sched_state_t state;
    sched_state_t state_next;
    logic         hit;
    logic         wd_fire;

    hop_counter #(
        .FRAME_LEN (FRAME_LEN),
        .HOP       (HOP)
    ) u_hop_counter (
        .clk   (clk),
        .reset (reset),
        .clear (!run),
        .new_t (new_t),
        .arm   (state == FILL),
        .hit   (hit)
    );

    // Handshake outputs are decoded straight from the registered state.
    assign link.snap_en     = (state == SNAP);
    assign link.fft_start   = (state == REQ);
    assign link.frame_valid = (state == PRESENT);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; run=0 overrides every transition.
    // NOTE: holding the current state as the default keeps this block free of latches.
    always_comb begin
        state_next = state;
        if (!run) begin
            state_next = FILL;
        end else begin
            case (state)
                FILL:      if (hit)             state_next = SNAP;
                SNAP:                           state_next = REQ;
                REQ:       if (link.fft_ready)  state_next = WAIT_DONE;
                WAIT_DONE: begin
                    if (link.fft_done)          state_next = PRESENT;
                    else if (wd_fire)           state_next = FILL;
                end
                PRESENT:   if (link.disp_ready) state_next = FILL;
                default:                        state_next = FILL;
            endcase
        end
    end

    // Frame statistics: a window completing outside FILL is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun     <= 1'b0;
            overrun_cnt <= '0;
            frame_cnt   <= '0;
        end else begin
            overrun <= hit && (state != FILL);
            if (hit && (state != FILL)) begin
                overrun_cnt <= sat_inc(overrun_cnt);
            end
            if (run && (state == PRESENT) && link.disp_ready) begin
                frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
            end
        end
    end

`ifdef FFT_SCHED_WATCHDOG_EN
    logic [WD_CNT_W-1:0] wd_cnt;

    // A done pulse in the final cycle still wins over the timeout.
    assign wd_fire = (state == WAIT_DONE) && !link.fft_done &&
                     (wd_cnt == WD_CNT_W'(TIMEOUT - 1));

    // Cycles spent in WAIT_DONE; restarts on every entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt <= '0;
        end else if (state == WAIT_DONE) begin
            wd_cnt <= wd_cnt + WD_CNT_W'(1);
        end else begin
            wd_cnt <= '0;
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeout_err <= 1'b0;
        end else if (run && wd_fire) begin
            timeout_err <= 1'b1;
        end
    end
`else
    assign wd_fire     = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule
